trivium_keystream_core: RTL and testbench
=========================================

Name: trivium_keystream_core

Overview:
Trivium keystream engine sitting directly downstream of the Trivium control FSM. It takes the assembled 80-bit key and 80-bit IV, runs the 1152-round warm-up, then serves one keystream byte per request, XORed with a data byte. The controller owns key collection and sequencing; this block owns the 288-bit cipher state and the keystream-usage limit.

Parameters:
ROUNDS_PER_CLK, 8, Trivium rounds per clock; fixed at 8, since one byte is produced per request.
INIT_CYCLES, 144, warm-up cycles; 1152 rounds / 8.
MAX_BYTES, 64'h2000_0000_0000_0000, bytes allowed per key/IV (2^61 bytes, i.e. 2^64 bits); lowered in test.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load  in  1  one-cycle pulse: latch key/iv and start warm-up
key  in  80  key; key[i] -> s(i+1)
iv  in  80  IV; iv[i] -> s(94+i)
ks_req  in  1  request one keystream byte
data  in  8  plaintext/ciphertext byte, sampled with ks_req
stream  out  8  data XOR keystream byte
ks_valid  out  1  one-cycle pulse, stream valid
busy  out  1  high during warm-up
ready  out  1  high while requests are accepted
exhausted  out  1  MAX_BYTES reached; a reload is required
err  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset: the state enters IDLE; s = 0, cnt_init = 0, byte_cnt = 0, stream = 0, and ks_valid, busy, ready, exhausted and err are all 0.
- State register s[287:0], with s[i] = s(i+1). On load:
  - s(1..80) = key, s(81..93) = 0
  - s(94..173) = iv, s(174..177) = 0
  - s(178..285) = 0, s(286..288) = 1
- One round:
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3
  - t1 ^= s91&s92 ^ s171; t2 ^= s175&s176 ^ s264; t3 ^= s286&s287 ^ s69
  - shift (s1..s93) <- (t3, s1..s92); (s94..s177) <- (t1, s94..s176); (s178..s288) <- (t2, s178..s287)
- Eight rounds are unrolled combinationally per clock. The first round's z goes to keystream bit 0 and the eighth round's z to bit 7.
- FSM states: IDLE, INIT, READY, EXHAUSTED.
  - IDLE: load -> INIT. A ks_req here pulses err; there is no ks_valid.
  - INIT: busy=1. Each cycle applies 8 rounds and discards z, and cnt_init increments. When cnt_init reaches INIT_CYCLES-1 the FSM goes to READY.
    - Timing: load at cycle 0 gives busy high over cycles 1..144 and ready=1 from cycle 145.
    - A ks_req during INIT pulses err and is otherwise ignored.
  - READY: ready=1. A ks_req applies 8 rounds, and on the next cycle stream = data ^ z[7:0] with a one-cycle ks_valid pulse (1-cycle latency). Back-to-back requests are accepted every cycle.
    - byte_cnt increments per accepted request. When the request that makes byte_cnt == MAX_BYTES is accepted, that byte is still delivered and the FSM goes to EXHAUSTED.
  - EXHAUSTED: exhausted=1, ready=0. A ks_req pulses err with no ks_valid. load -> INIT and clears exhausted.
- load in any state, including mid-INIT and mid-READY, restarts: the state is reloaded, cnt_init and byte_cnt are cleared, and the FSM enters INIT. Load has priority over a ks_req in the same cycle; that request is dropped without err.
- stream holds its last value between valid pulses. Consumers use ks_valid only.
- err and ks_valid are never high in the same cycle.
- Async reset mid-operation returns everything to the reset values immediately. The state is not preserved.

Decomposition:
- Package trivium_pkg holds:
  - state enum (IDLE, INIT, READY, EXHAUSTED)
  - constants KEY_W=80, IV_W=80, STATE_W=288, INIT_ROUNDS=1152
  - tap index localparams (66, 93, 162, 177, 243, 288, 91, 92, 171, 175, 176, 264, 286, 287, 69)
- One combinational sub-module, trivium_round8: s_in[287:0] -> s_out[287:0], z[7:0]. It is instantiated once and reused for both warm-up and keystream.

Test Plan:
- Reset then idle: rst high mid-cycle -> all outputs 0 asynchronously; ks_req in IDLE -> err pulse, no ks_valid.
- key=0, iv=0, load at cycle 0 -> busy cycles 1..144, ready at cycle 145; 16 back-to-back ks_req with data=0 -> 16 consecutive ks_valid pulses; stream bytes equal the golden software model's first 16 keystream bytes, bit 0 first.
- Round trip: encrypt bytes 0x00..0x0F with key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA9876543210FEDC, reload the same key/IV, decrypt -> original bytes recovered exactly.
- ks_req at cycle 50 of INIT -> err pulse, no ks_valid, ready still rises at cycle 145; reload at cycle 100 of INIT -> ready rises 145 cycles after the second load.
- MAX_BYTES=4: five requests -> four ks_valid pulses; exhausted=1 after the 4th; the 5th request gives an err pulse; load -> exhausted=0, warm-up restarts.
- load and ks_req in the same cycle while READY -> no ks_valid, no err; busy=1 next cycle.

Source files
------------

// File: rtl/trivium_keystream_core_pkg.sv
// Shared definitions for the Trivium keystream engine: widths, FSM
// encodings, feedback tap positions and the key/IV load layout.
package trivium_pkg;

    localparam int KEY_W          = 80;
    localparam int IV_W           = 80;
    localparam int STATE_W        = 288;
    localparam int INIT_ROUNDS    = 1152;
    localparam int ROUNDS_PER_CLK = 8;

    // FSM encodings, kept as plain constants for legacy tool flows
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_INIT      = 2'd1;
    localparam logic [1:0] ST_READY     = 2'd2;
    localparam logic [1:0] ST_EXHAUSTED = 2'd3;

    // Tap positions use the 1-based s(n) numbering; s(n) lives in bit n-1
    localparam int TAP_66  = 66;
    localparam int TAP_93  = 93;
    localparam int TAP_162 = 162;
    localparam int TAP_177 = 177;
    localparam int TAP_243 = 243;
    localparam int TAP_288 = 288;
    localparam int TAP_91  = 91;
    localparam int TAP_92  = 92;
    localparam int TAP_171 = 171;
    localparam int TAP_175 = 175;
    localparam int TAP_176 = 176;
    localparam int TAP_264 = 264;
    localparam int TAP_286 = 286;
    localparam int TAP_287 = 287;
    localparam int TAP_69  = 69;

    // Initial cipher state: key in s(1..80), IV in s(94..173), s(286..288) set
    function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                       input logic [IV_W-1:0]  iv);
        return {3'b111, 112'b0, iv, 13'b0, key};
    endfunction

endpackage

// File: rtl/trivium_keystream_core_if.sv
// Control/data bundle between the Trivium controller and the keystream core.
interface trivium_keystream_core_if;
    import trivium_pkg::*;

    logic              load;
    logic [KEY_W-1:0]  key;
    logic [IV_W-1:0]   iv;
    logic              ks_req;
    logic [7:0]        data;
    logic [7:0]        stream;
    logic              ks_valid;
    logic              busy;
    logic              ready;
    logic              exhausted;
    logic              err;

    modport master (
        output load, key, iv, ks_req, data,
        input  stream, ks_valid, busy, ready, exhausted, err
    );

    modport slave (
        input  load, key, iv, ks_req, data,
        output stream, ks_valid, busy, ready, exhausted, err
    );

endinterface

// File: rtl/trivium_round8.sv
// Eight Trivium rounds unrolled combinationally; z_o[0] is the first round.
module trivium_round8
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] s_i,
    output logic [STATE_W-1:0] s_o,
    output logic [7:0]         z_o
);

    // Chain the rounds, collecting each round's output bit in order
    always_comb begin
        logic [STATE_W-1:0] st;
        logic t1;
        logic t2;
        logic t3;
        st  = s_i;
        z_o = '0;
        t1  = 1'b0;
        t2  = 1'b0;
        t3  = 1'b0;
        for (int r = 0; r < ROUNDS_PER_CLK; r++) begin
            t1 = st[TAP_66-1]  ^ st[TAP_93-1];
            t2 = st[TAP_162-1] ^ st[TAP_177-1];
            t3 = st[TAP_243-1] ^ st[TAP_288-1];
            z_o[r[2:0]] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (st[TAP_91-1]  & st[TAP_92-1])  ^ st[TAP_171-1];
            t2 = t2 ^ (st[TAP_175-1] & st[TAP_176-1]) ^ st[TAP_264-1];
            t3 = t3 ^ (st[TAP_286-1] & st[TAP_287-1]) ^ st[TAP_69-1];
            st = {st[286:177], t2, st[175:93], t1, st[91:0], t3};
        end
        s_o = st;
    end

endmodule

// File: rtl/trivium_keystream_core.sv
// Trivium keystream engine: owns the 288-bit cipher state, runs the warm-up
// after each load and serves one data^keystream byte per accepted request.
module trivium_keystream_core
    import trivium_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 144,
    parameter logic [63:0] MAX_BYTES   = 64'h2000_0000_0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    trivium_keystream_core_if.slave       bus
);

    localparam int CNT_W = $clog2(INIT_CYCLES);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_init_q, cnt_init_d;
    logic [63:0]        byte_cnt_q, byte_cnt_d;
    logic [STATE_W-1:0] s_q, s_d, s_next;
    logic [7:0]         z;
    logic [7:0]         stream_q, stream_d;
    logic               ks_valid_q, ks_valid_d;
    logic               err_q, err_d;

    trivium_round8 u_round8 (
        .s_i (s_q),
        .s_o (s_next),
        .z_o (z)
    );

    // Next-state logic: load overrides everything, otherwise per-state handling
    always_comb begin
        state_d    = state_q;
        cnt_init_d = cnt_init_q;
        byte_cnt_d = byte_cnt_q;
        s_d        = s_q;
        stream_d   = stream_q;
        ks_valid_d = 1'b0;
        err_d      = 1'b0;
        if (bus.load) begin
            s_d        = load_state(bus.key, bus.iv);
            cnt_init_d = '0;
            byte_cnt_d = '0;
            state_d    = ST_INIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    err_d = bus.ks_req;
                end
                ST_INIT: begin
                    err_d      = bus.ks_req;
                    s_d        = s_next;
                    cnt_init_d = cnt_init_q + 1'b1;
                    if (cnt_init_q == CNT_W'(INIT_CYCLES - 1)) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (bus.ks_req) begin
                        s_d        = s_next;
                        stream_d   = bus.data ^ z;
                        ks_valid_d = 1'b1;
                        byte_cnt_d = byte_cnt_q + 64'd1;
                        if (byte_cnt_d == MAX_BYTES) begin
                            state_d = ST_EXHAUSTED;
                        end
                    end
                end
                ST_EXHAUSTED: begin
                    err_d = bus.ks_req;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset discards the cipher state entirely
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_init_q <= '0;
            byte_cnt_q <= '0;
            s_q        <= '0;
            stream_q   <= '0;
            ks_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_init_q <= cnt_init_d;
            byte_cnt_q <= byte_cnt_d;
            s_q        <= s_d;
            stream_q   <= stream_d;
            ks_valid_q <= ks_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.stream    = stream_q;
    assign bus.ks_valid  = ks_valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q == ST_INIT);
    assign bus.ready     = (state_q == ST_READY);
    assign bus.exhausted = (state_q == ST_EXHAUSTED);

endmodule

// File: tb/tb_trivium_keystream_core.sv
// Self-checking bench for trivium_keystream_core. A second instance with a
// tiny byte limit shares the same stimulus to exercise exhaustion.
module tb_trivium_keystream_core;

    logic        clk;
    logic        rst;
    logic        load;
    logic        ksReq;
    logic [7:0]  data;
    logic [79:0] key;
    logic [79:0] iv;

    int total = 0;
    int bad   = 0;

    // Reference cipher state, 1-based exactly as s(1..288)
    bit ms [1:288];

    typedef struct {
        logic [7:0] dataIn;
        logic [7:0] expStream;
    } vec_t;

    vec_t       rtVec [16];
    logic [7:0] cipher [16];

    trivium_keystream_core_if busA ();
    trivium_keystream_core_if busX ();

    assign busA.load   = load;
    assign busA.key    = key;
    assign busA.iv     = iv;
    assign busA.ks_req = ksReq;
    assign busA.data   = data;
    assign busX.load   = load;
    assign busX.key    = key;
    assign busX.iv     = iv;
    assign busX.ks_req = ksReq;
    assign busX.data   = data;

    trivium_keystream_core dut (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    trivium_keystream_core #(.MAX_BYTES(64'd4)) dutX (
        .clk (clk),
        .rst (rst),
        .bus (busX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One clock: drive inputs, let the edge capture them, sample 1ns later
    task automatic applyStimulus(input logic ld, input logic req, input logic [7:0] d);
        load  = ld;
        ksReq = req;
        data  = d;
        @(posedge clk);
        #1;
        load  = 1'b0;
        ksReq = 1'b0;
    endtask

    task automatic modelLoad(input logic [79:0] k, input logic [79:0] v);
        for (int n = 1; n <= 288; n++) ms[n] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ms[i + 1]  = k[i];
            ms[94 + i] = v[i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
    endtask

    task automatic modelByte(output logic [7:0] b);
        bit t1, t2, t3;
        b = '0;
        for (int r = 0; r < 8; r++) begin
            t1 = ms[66] ^ ms[93];
            t2 = ms[162] ^ ms[177];
            t3 = ms[243] ^ ms[288];
            b[r] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
            t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
            t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
            for (int n = 288; n >= 2; n--) begin
                if (n != 94 && n != 178) ms[n] = ms[n - 1];
            end
            ms[1]   = t3;
            ms[94]  = t1;
            ms[178] = t2;
        end
    endtask

    // Reference warm-up: 1152 rounds with z discarded
    task automatic modelWarmup();
        logic [7:0] dummy;
        for (int c = 0; c < 144; c++) modelByte(dummy);
    endtask

    // Counts busy cycles until ready rises, bounded so the bench cannot hang
    task automatic waitReady(output int n);
        int guard;
        n     = 0;
        guard = 0;
        while (!busA.ready && guard < 400) begin
            if (busA.busy) n++;
            guard++;
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
        checkOutput("ready_rise", 64'(busA.ready), 64'd1);
    endtask

    initial begin
        int         n;
        logic [7:0] m;
        logic [7:0] d;
        logic       req;

        rst   = 1'b0;
        load  = 1'b0;
        ksReq = 1'b0;
        data  = 8'h00;
        key   = '0;
        iv    = '0;

        // Reset asserted between edges must clear outputs without a clock
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_outputs", 64'({busA.stream, busA.ks_valid, busA.busy, busA.ready,
                                          busA.exhausted, busA.err}), 64'd0);
        #20 rst = 1'b0;
        @(posedge clk);
        #1;

        // Request in IDLE is illegal
        applyStimulus(1'b0, 1'b1, 8'hA5);
        checkOutput("idle_err", 64'(busA.err), 64'd1);
        checkOutput("idle_no_valid", 64'(busA.ks_valid), 64'd0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("idle_err_pulse", 64'(busA.err), 64'd0);

        // All-zero key/IV: warm-up timing then 16 back-to-back bytes
        key = '0;
        iv  = '0;
        modelLoad(key, iv);
        modelWarmup();
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitReady(n);
        checkOutput("busy_cycles_zero_key", 64'(n), 64'd144);
        for (int i = 0; i < 16; i++) begin
            modelByte(m);
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("zero_key_valid", 64'(busA.ks_valid), 64'd1);
            checkOutput("zero_key_stream", 64'(busA.stream), 64'(m));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("valid_drops", 64'(busA.ks_valid), 64'd0);
        checkOutput("stream_holds", 64'(busA.stream), 64'(m));

        // Round trip table: expected ciphertext comes from the model
        key = 80'h0123456789ABCDEF0123;
        iv  = 80'hFEDCBA9876543210FEDC;
        modelLoad(key, iv);
        modelWarmup();
        for (int i = 0; i < 16; i++) begin
            modelByte(m);
            rtVec[i].dataIn    = 8'(i);
            rtVec[i].expStream = 8'(i) ^ m;
        end
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitReady(n);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, rtVec[i].dataIn);
            checkOutput("encrypt", 64'(busA.stream), 64'(rtVec[i].expStream));
            cipher[i] = busA.stream;
        end
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitReady(n);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, cipher[i]);
            checkOutput("decrypt", 64'(busA.stream), 64'(rtVec[i].dataIn));
        end

        // Random keys, IVs, data and request gaps
        for (int k = 0; k < 3; k++) begin
            key = {$urandom(), $urandom(), 16'($urandom())};
            iv  = {$urandom(), $urandom(), 16'($urandom())};
            modelLoad(key, iv);
            modelWarmup();
            applyStimulus(1'b1, 1'b0, 8'h00);
            waitReady(n);
            for (int j = 0; j < 12; j++) begin
                req = 1'($urandom_range(0, 1));
                d   = 8'($urandom());
                if (req) modelByte(m);
                applyStimulus(1'b0, req, d);
                checkOutput("rand_valid", 64'(busA.ks_valid), 64'(req));
                checkOutput("rand_no_err", 64'(busA.err), 64'd0);
                if (req) checkOutput("rand_stream", 64'(busA.stream), 64'(d ^ m));
            end
        end

        // Request during warm-up is rejected and does not disturb timing
        key = 80'h1111_2222_3333_4444_5555;
        iv  = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int c = 1; c < 50; c++) applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h3C);
        checkOutput("init_err", 64'(busA.err), 64'd1);
        checkOutput("init_no_valid", 64'(busA.ks_valid), 64'd0);
        waitReady(n);
        checkOutput("busy_cycles_with_req", 64'(n + 50), 64'd144);

        // Reload mid warm-up restarts the full warm-up with the new key
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int c = 1; c < 100; c++) applyStimulus(1'b0, 1'b0, 8'h00);
        key = 80'h0F0F_F0F0_1234_5678_9ABC;
        iv  = 80'h0000_1111_2222_3333_4444;
        modelLoad(key, iv);
        modelWarmup();
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitReady(n);
        checkOutput("busy_cycles_reload", 64'(n), 64'd144);
        modelByte(m);
        applyStimulus(1'b0, 1'b1, 8'h5A);
        checkOutput("reload_stream", 64'(busA.stream), 64'(8'h5A ^ m));

        // Byte limit of 4 on the second instance
        modelLoad(key, iv);
        modelWarmup();
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitReady(n);
        for (int i = 0; i < 4; i++) begin
            modelByte(m);
            d = 8'(8'h10 + i);
            applyStimulus(1'b0, 1'b1, d);
            checkOutput("lim_valid", 64'(busX.ks_valid), 64'd1);
            checkOutput("lim_stream", 64'(busX.stream), 64'(d ^ m));
            checkOutput("lim_exhausted", 64'(busX.exhausted), 64'(i == 3));
        end
        checkOutput("lim_not_ready", 64'(busX.ready), 64'd0);
        applyStimulus(1'b0, 1'b1, 8'h77);
        checkOutput("lim_err", 64'(busX.err), 64'd1);
        checkOutput("lim_no_valid", 64'(busX.ks_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("lim_cleared", 64'(busX.exhausted), 64'd0);
        checkOutput("lim_rewarm", 64'(busX.busy), 64'd1);

        // Load wins over a same-cycle request in READY
        waitReady(n);
        applyStimulus(1'b1, 1'b1, 8'h99);
        checkOutput("loadreq_no_valid", 64'(busA.ks_valid), 64'd0);
        checkOutput("loadreq_no_err", 64'(busA.err), 64'd0);
        checkOutput("loadreq_busy", 64'(busA.busy), 64'd1);

        // Asynchronous reset in the middle of keystream service
        waitReady(n);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        #3 rst = 1'b1;
        #1;
        checkOutput("midop_reset", 64'({busA.stream, busA.ks_valid, busA.busy, busA.ready,
                                        busA.exhausted, busA.err}), 64'd0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 8'h01);
        checkOutput("post_reset_idle_err", 64'(busA.err), 64'd1);
        checkOutput("post_reset_no_valid", 64'(busA.ks_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
